// File: rtl/mem_port_arbiter_if.sv
// Access-size encoding and the single-port memory array interface shared by the
// fetch/data arbiter and the memory array it drives (one clock, sync active-high reset).
package mem_access_pkg;
   typedef enum logic [1:0] {
      MEM_BYTE = 2'd0,
      MEM_HALF = 2'd1,
      MEM_WORD = 2'd2
   } mem_access_size_t;
endpackage

interface mem_array_if;
   import mem_access_pkg::*;

   // Read is combinational (rd_data follows rd_addr/rd_size, right-aligned);
   // write commits at the posedge of the cycle wr_enable is high.
   logic [31:0]      rd_addr;
   mem_access_size_t rd_size;
   logic [31:0]      rd_data;
   logic             wr_enable;
   logic [31:0]      wr_addr;
   logic [31:0]      wr_data;
   mem_access_size_t wr_size;

   modport slave (
      output rd_addr, rd_size, wr_enable, wr_addr, wr_data, wr_size,
      input  rd_data
   );

   modport master (
      input  rd_addr, rd_size, wr_enable, wr_addr, wr_data, wr_size,
      output rd_data
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access: one grant per cycle,
// registered single-cycle responses, misaligned requests answered with an error.
module mem_port_arbiter
   import mem_access_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic             clk_i,
   input  logic             reset_i,
   // Handshake: a request is accepted in the cycle valid && ready are both high.
   // ready is combinational from valid and arbiter state; nothing is queued, so a
   // requester holds valid and its fields until accepted. Responses are one-cycle
   // pulses exactly one cycle after acceptance and cannot be back-pressured.
   input  logic             if_req_valid_i,
   output logic             if_req_ready_o,
   input  logic [31:0]      if_addr_i,
   output logic             if_rsp_valid_o,
   output logic [31:0]      if_rsp_data_o,
   output logic             if_rsp_err_o,
   input  logic             dc_req_valid_i,
   output logic             dc_req_ready_o,
   input  logic             dc_we_i,
   input  mem_access_size_t dc_size_i,
   input  logic [31:0]      dc_addr_i,
   input  logic [31:0]      dc_wr_data_i,
   output logic             dc_rsp_valid_o,
   output logic [31:0]      dc_rsp_data_o,
   output logic             dc_rsp_err_o,
   mem_array_if.slave       memif
);

   localparam int unsigned          CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STARVE_LIMIT);

   function automatic logic is_misaligned(mem_access_size_t size, logic [1:0] lsb);
      case (size)
         MEM_BYTE: return 1'b0;
         MEM_HALF: return lsb[0];
         default:  return (lsb != 2'b00);
      endcase
   endfunction

   function automatic logic [31:0] size_mask(mem_access_size_t size, logic [31:0] data);
      case (size)
         MEM_BYTE: return {24'd0, data[7:0]};
         MEM_HALF: return {16'd0, data[15:0]};
         default:  return data;
      endcase
   endfunction

   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             if_rsp_valid_q, if_rsp_valid_d;
   logic [31:0]      if_rsp_data_q, if_rsp_data_d;
   logic             if_rsp_err_q, if_rsp_err_d;
   logic             dc_rsp_valid_q, dc_rsp_valid_d;
   logic [31:0]      dc_rsp_data_q, dc_rsp_data_d;
   logic             dc_rsp_err_q, dc_rsp_err_d;

   logic fetch_wins;
   logic grant_if;
   logic grant_dc;
   logic if_misaligned;
   logic dc_misaligned;

   always_comb begin
      // Data wins ties unless fetch has been held off for STARVE_LIMIT cycles.
      fetch_wins    = if_req_valid_i && (!dc_req_valid_i || (starve_cnt_q == CNT_MAX));
      grant_if      = !reset_i && fetch_wins;
      grant_dc      = !reset_i && dc_req_valid_i && !fetch_wins;
      if_misaligned = (if_addr_i[1:0] != 2'b00);
      dc_misaligned = is_misaligned(dc_size_i, dc_addr_i[1:0]);

      starve_cnt_d = '0;
      if (if_req_valid_i && !grant_if) begin
         starve_cnt_d = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + 1'b1;
      end

      memif.rd_addr   = '0;
      memif.rd_size   = MEM_WORD;
      if (grant_if) begin
         memif.rd_addr = if_addr_i;
      end else if (grant_dc) begin
         memif.rd_addr = dc_addr_i;
         memif.rd_size = dc_size_i;
      end
      memif.wr_enable = grant_dc && dc_we_i && !dc_misaligned;
      memif.wr_addr   = dc_addr_i;
      memif.wr_data   = dc_wr_data_i;
      memif.wr_size   = dc_size_i;

      // Response payloads hold their last value until the next response for that port.
      if_rsp_valid_d = grant_if;
      if_rsp_data_d  = if_rsp_data_q;
      if_rsp_err_d   = if_rsp_err_q;
      if (grant_if) begin
         if_rsp_err_d  = if_misaligned;
         if_rsp_data_d = if_misaligned ? 32'd0 : memif.rd_data;
      end

      dc_rsp_valid_d = grant_dc;
      dc_rsp_data_d  = dc_rsp_data_q;
      dc_rsp_err_d   = dc_rsp_err_q;
      if (grant_dc) begin
         dc_rsp_err_d  = dc_misaligned;
         dc_rsp_data_d = (dc_misaligned || dc_we_i) ? 32'd0
                                                    : size_mask(dc_size_i, memif.rd_data);
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         starve_cnt_q   <= '0;
         if_rsp_valid_q <= 1'b0;
         if_rsp_data_q  <= '0;
         if_rsp_err_q   <= 1'b0;
         dc_rsp_valid_q <= 1'b0;
         dc_rsp_data_q  <= '0;
         dc_rsp_err_q   <= 1'b0;
      end else begin
         starve_cnt_q   <= starve_cnt_d;
         if_rsp_valid_q <= if_rsp_valid_d;
         if_rsp_data_q  <= if_rsp_data_d;
         if_rsp_err_q   <= if_rsp_err_d;
         dc_rsp_valid_q <= dc_rsp_valid_d;
         dc_rsp_data_q  <= dc_rsp_data_d;
         dc_rsp_err_q   <= dc_rsp_err_d;
      end
   end

   assign if_req_ready_o = grant_if;
   assign dc_req_ready_o = grant_dc;
   assign if_rsp_valid_o = if_rsp_valid_q;
   assign if_rsp_data_o  = if_rsp_data_q;
   assign if_rsp_err_o   = if_rsp_err_q;
   assign dc_rsp_valid_o = dc_rsp_valid_q;
   assign dc_rsp_data_o  = dc_rsp_data_q;
   assign dc_rsp_err_o   = dc_rsp_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: byte-array memory device, directed scenarios, then random
// traffic checked against a transaction-level model of arbitration and memory contents.
module tb_mem_port_arbiter;
   import mem_access_pkg::*;

   localparam int STARVE_LIMIT = 4;

   logic             clk;
   logic             rst;
   logic             if_valid, if_ready, if_rsp_valid, if_rsp_err;
   logic [31:0]      if_addr, if_rsp_data;
   logic             dc_valid, dc_ready, dc_we, dc_rsp_valid, dc_rsp_err;
   mem_access_size_t dc_size;
   logic [31:0]      dc_addr, dc_wr_data, dc_rsp_data;

   mem_array_if mif ();

   mem_port_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk_i          (clk),
      .reset_i        (rst),
      .if_req_valid_i (if_valid),
      .if_req_ready_o (if_ready),
      .if_addr_i      (if_addr),
      .if_rsp_valid_o (if_rsp_valid),
      .if_rsp_data_o  (if_rsp_data),
      .if_rsp_err_o   (if_rsp_err),
      .dc_req_valid_i (dc_valid),
      .dc_req_ready_o (dc_ready),
      .dc_we_i        (dc_we),
      .dc_size_i      (dc_size),
      .dc_addr_i      (dc_addr),
      .dc_wr_data_i   (dc_wr_data),
      .dc_rsp_valid_o (dc_rsp_valid),
      .dc_rsp_data_o  (dc_rsp_data),
      .dc_rsp_err_o   (dc_rsp_err),
      .memif          (mif)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   function automatic int nbytes(mem_access_size_t s);
      case (s)
         MEM_BYTE: return 1;
         MEM_HALF: return 2;
         default:  return 4;
      endcase
   endfunction

   function automatic logic [11:0] bidx(logic [31:0] a, int i);
      return 12'(a + 32'(i));
   endfunction

   // ---------------- memory device (environment) ----------------
   logic [7:0]  dev_mem [0:4095] = '{default: 8'h00};
   logic        pl_en = 1'b0;
   logic [31:0] pl_addr = '0;
   logic [31:0] pl_data = '0;

   always_comb begin
      mif.rd_data = '0;
      for (int i = 0; i < 4; i++) begin
         if (i < nbytes(mif.rd_size)) mif.rd_data[8*i +: 8] = dev_mem[bidx(mif.rd_addr, i)];
      end
   end

   always @(posedge clk) begin
      if (mif.wr_enable) begin
         for (int i = 0; i < 4; i++) begin
            if (i < nbytes(mif.wr_size)) dev_mem[bidx(mif.wr_addr, i)] <= mif.wr_data[8*i +: 8];
         end
      end
      if (pl_en) begin
         for (int i = 0; i < 4; i++) dev_mem[bidx(pl_addr, i)] <= pl_data[8*i +: 8];
      end
   end

   function automatic logic [31:0] dev_word(logic [31:0] a);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = dev_mem[bidx(a, i)];
      return v;
   endfunction

   // ---------------- reference model ----------------
   logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
   int          starve;
   logic        m_if_v, m_if_e, m_dc_v, m_dc_e;
   logic [31:0] m_if_d, m_dc_d;
   logic        last_gi, last_gd;

   function automatic logic mis(logic [31:0] a, mem_access_size_t s);
      return (a % 32'(nbytes(s))) != 0;
   endfunction

   function automatic logic [31:0] ref_read(logic [31:0] a, mem_access_size_t s);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < nbytes(s); i++) v = v | (32'(ref_mem[bidx(a, i)]) << (8 * i));
      return v;
   endfunction

   task automatic ref_write(input logic [31:0] a, input mem_access_size_t s, input logic [31:0] d);
      for (int i = 0; i < nbytes(s); i++) ref_mem[bidx(a, i)] = d[8*i +: 8];
   endtask

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic preload_word(input logic [31:0] a, input logic [31:0] d);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      ref_write(a, MEM_WORD, d);
      @(posedge clk);
      #1 pl_en = 1'b0;
      @(negedge clk);
   endtask

   // Called just after a negedge with the cycle's inputs already applied.
   task automatic do_cycle();
      logic fw, gi, gd;
      #1;
      fw = if_valid && (!dc_valid || starve == STARVE_LIMIT);
      gi = !rst && fw;
      gd = !rst && dc_valid && !fw;
      check("if_ready", 32'(if_ready), 32'(gi));
      check("dc_ready", 32'(dc_ready), 32'(gd));
      check("wr_enable", 32'(mif.wr_enable), 32'(gd && dc_we && !mis(dc_addr, dc_size)));
      last_gi = gi;
      last_gd = gd;
      @(posedge clk);
      if (rst) begin
         starve = 0;
         {m_if_v, m_if_e, m_dc_v, m_dc_e} = '0;
         m_if_d = '0;
         m_dc_d = '0;
      end else begin
         m_if_v = gi;
         m_dc_v = gd;
         if (gi) begin
            m_if_e = mis(if_addr, MEM_WORD);
            m_if_d = m_if_e ? 32'd0 : ref_read(if_addr, MEM_WORD);
         end
         if (gd) begin
            m_dc_e = mis(dc_addr, dc_size);
            m_dc_d = (m_dc_e || dc_we) ? 32'd0 : ref_read(dc_addr, dc_size);
            if (dc_we && !m_dc_e) ref_write(dc_addr, dc_size, dc_wr_data);
         end
         starve = (if_valid && !gi) ? ((starve < STARVE_LIMIT) ? starve + 1 : STARVE_LIMIT) : 0;
      end
      #1;
      check("if_rsp_valid", 32'(if_rsp_valid), 32'(m_if_v));
      check("if_rsp_data",  if_rsp_data,       m_if_d);
      check("if_rsp_err",   32'(if_rsp_err),   32'(m_if_e));
      check("dc_rsp_valid", 32'(dc_rsp_valid), 32'(m_dc_v));
      check("dc_rsp_data",  dc_rsp_data,       m_dc_d);
      check("dc_rsp_err",   32'(dc_rsp_err),   32'(m_dc_e));
      @(negedge clk);
   endtask

   task automatic set_idle();
      if_valid = 1'b0; dc_valid = 1'b0; dc_we = 1'b0;
   endtask

   task automatic set_dc(input logic we, input mem_access_size_t s, input logic [31:0] a,
                         input logic [31:0] d);
      dc_valid = 1'b1; dc_we = we; dc_size = s; dc_addr = a; dc_wr_data = d;
   endtask

   // ---------------- stimulus ----------------
   logic [9:0] t2_pat;

   initial begin
      rst = 1'b1;
      if_valid = 1'b0; if_addr = '0;
      dc_valid = 1'b0; dc_we = 1'b0; dc_size = MEM_WORD; dc_addr = '0; dc_wr_data = '0;
      starve = 0;
      {m_if_v, m_if_e, m_dc_v, m_dc_e} = '0;
      m_if_d = '0; m_dc_d = '0;
      last_gi = 1'b0; last_gd = 1'b0;
      @(negedge clk);

      preload_word(32'h100, 32'hDEADBEEF);
      preload_word(32'h104, 32'hCAFEF00D);
      preload_word(32'h040, 32'h11223344);
      preload_word(32'h030, 32'h80000000);
      for (int i = 0; i < 16; i++) preload_word(32'h400 + 32'(i * 4), $urandom);

      // Reset: requests present but nothing may be granted.
      if_valid = 1'b1; if_addr = 32'h100;
      set_dc(1'b1, MEM_WORD, 32'h40, 32'hFFFFFFFF);
      do_cycle();
      do_cycle();
      rst = 1'b0;
      set_idle();
      do_cycle();

      // Fetch only from 0x100.
      if_valid = 1'b1; if_addr = 32'h100;
      do_cycle();
      check("t1_if_data", if_rsp_data, 32'hDEADBEEF);
      set_idle();
      do_cycle();

      // Both valid for 10 cycles: D,D,D,D,I,D,D,D,D,I.
      t2_pat = 10'b10000_10000;
      if_valid = 1'b1; if_addr = 32'h100;
      set_dc(1'b0, MEM_WORD, 32'h104, 32'h0);
      for (int i = 0; i < 10; i++) begin
         #1;
         check("t2_if_grant", 32'(if_ready), 32'(t2_pat[i]));
         check("t2_dc_grant", 32'(dc_ready), 32'(!t2_pat[i]));
         do_cycle();
      end
      set_idle();
      do_cycle();

      // Store byte then word load back-to-back.
      set_dc(1'b1, MEM_BYTE, 32'h203, 32'h000000A5);
      do_cycle();
      check("t3_store_data", dc_rsp_data, 32'h0);
      set_dc(1'b0, MEM_WORD, 32'h200, 32'h0);
      do_cycle();
      check("t3_load_data", dc_rsp_data, 32'hA5000000);

      // Misaligned half load and fetch, both valid.
      if_valid = 1'b1; if_addr = 32'h102;
      set_dc(1'b0, MEM_HALF, 32'h101, 32'h0);
      do_cycle();
      check("t4_dc_err", 32'(dc_rsp_err), 32'd1);
      dc_valid = 1'b0;
      do_cycle();
      check("t4_if_err", 32'(if_rsp_err), 32'd1);
      check("t4_if_data", if_rsp_data, 32'h0);
      set_idle();
      do_cycle();

      // Reset asserted in the cycle a store would be granted, with a load response pending.
      set_dc(1'b0, MEM_WORD, 32'h104, 32'h0);
      do_cycle();
      set_dc(1'b1, MEM_WORD, 32'h40, 32'h12345678);
      rst = 1'b1;
      do_cycle();
      check("t5_mem_unchanged", dev_word(32'h40), 32'h11223344);
      rst = 1'b0;
      set_idle();
      do_cycle();
      check("t5_no_dc_rsp", 32'(dc_rsp_valid), 32'd0);

      // Byte load zero-extension.
      set_dc(1'b0, MEM_BYTE, 32'h33, 32'h0);
      do_cycle();
      check("t6_byte_data", dc_rsp_data, 32'h00000080);
      set_idle();
      do_cycle();

      // Random traffic; a requester holds its request until accepted.
      for (int n = 0; n < 300; n++) begin
         rst = ($urandom_range(0, 59) == 0);
         if (!if_valid || last_gi) begin
            if_valid = ($urandom_range(0, 3) != 0);
            if_addr  = $urandom_range(32'h3C0, 32'h4FF);
            if ($urandom_range(0, 7) != 0) if_addr[1:0] = 2'b00;
         end
         if (!dc_valid || last_gd) begin
            dc_valid   = ($urandom_range(0, 3) != 0);
            dc_we      = $urandom_range(0, 1) == 1;
            dc_size    = mem_access_size_t'($urandom_range(0, 2));
            dc_addr    = $urandom_range(32'h3C0, 32'h4FF);
            dc_wr_data = $urandom;
            if ($urandom_range(0, 7) != 0) dc_addr = dc_addr & ~(32'(nbytes(dc_size)) - 1);
         end
         do_cycle();
      end
      rst = 1'b0;
      set_idle();
      do_cycle();
      for (int a = 32'h3C0; a < 32'h500; a += 4) check("final_mem", dev_word(32'(a)), ref_read(32'(a), MEM_WORD));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
